// File: rtl/seq_mag_comparator_if.sv
// Handshake and operand/result bundle for seq_mag_comparator.
// The master side issues compares; the slave side is the comparator.
interface seq_mag_comparator_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             busy;
    logic             done;
    logic             aeqb;
    logic             agtb;
    logic             altb;

    modport master (
        output start, a, b, is_signed,
        input  busy, done, aeqb, agtb, altb
    );

    modport slave (
        input  start, a, b, is_signed,
        output busy, done, aeqb, agtb, altb
    );
endinterface

// File: rtl/seq_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle, signed or unsigned.
// Define CMP_EARLY_EXIT_EN to finish at the first differing chunk instead of always scanning all chunks.
module seq_mag_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic                clk,
    input logic                rst_n,
    seq_mag_comparator_if.slave bus
);
    localparam int NCHUNK = WIDTH / DIGIT;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {REL_EQ, REL_GT, REL_LT} rel_t;

    state_t             state;
    rel_t               rel;
    rel_t               chunk_rel;
    rel_t               next_rel;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [IDX_W-1:0]   idx;
    logic               last_chunk;
    logic               finish;
    logic               busy_q;
    logic               done_q;
    logic               aeqb_q;
    logic               agtb_q;
    logic               altb_q;

    logic [DIGIT-1:0]   chunk_a [NCHUNK];
    logic [DIGIT-1:0]   chunk_b [NCHUNK];

    for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
        assign chunk_a[g] = op_a[WIDTH-1-g*DIGIT -: DIGIT];
        assign chunk_b[g] = op_b[WIDTH-1-g*DIGIT -: DIGIT];
    end

    always_comb begin
        chunk_rel = REL_EQ;
        if (chunk_a[idx] > chunk_b[idx]) begin
            chunk_rel = REL_GT;
        end else if (chunk_a[idx] < chunk_b[idx]) begin
            chunk_rel = REL_LT;
        end
        next_rel   = (rel == REL_EQ) ? chunk_rel : rel;
        last_chunk = (idx == IDX_W'(NCHUNK - 1));
`ifdef CMP_EARLY_EXIT_EN
        finish     = last_chunk || (next_rel != REL_EQ);
`else
        finish     = last_chunk;
`endif
    end

    // Signed operands are stored offset-binary (MSB flipped) so the scan is always unsigned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rel    <= REL_EQ;
            op_a   <= '0;
            op_b   <= '0;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            aeqb_q <= 1'b0;
            agtb_q <= 1'b0;
            altb_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_a   <= {bus.a[WIDTH-1] ^ bus.is_signed, bus.a[WIDTH-2:0]};
                        op_b   <= {bus.b[WIDTH-1] ^ bus.is_signed, bus.b[WIDTH-2:0]};
                        idx    <= '0;
                        rel    <= REL_EQ;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    rel <= next_rel;
                    idx <= idx + 1'b1;
                    if (finish) begin
                        aeqb_q <= (next_rel == REL_EQ);
                        agtb_q <= (next_rel == REL_GT);
                        altb_q <= (next_rel == REL_LT);
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.aeqb = aeqb_q;
    assign bus.agtb = agtb_q;
    assign bus.altb = altb_q;
endmodule

// File: tb/tb_seq_mag_comparator.sv
// Scoreboard bench for seq_mag_comparator at WIDTH=8, DIGIT=2 (four chunks).
// Driver pushes hand-computed expectations; a negedge monitor pops them on every done pulse.
module tb_seq_mag_comparator;
    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam logic [2:0] F_EQ = 3'b100;
    localparam logic [2:0] F_GT = 3'b010;
    localparam logic [2:0] F_LT = 3'b001;

    typedef struct {
        logic [2:0] flags;
        int         lat;
        int         start_cycle;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [2:0] flags;
        int         lat_early;
    } vec_t;

    logic clk;
    logic rst_n;
    int   cycle;
    int   errors;
    int   checks;
    int   done_count;
    int   issued;
    logic prev_done;
    logic [2:0] last_flags;
    exp_t sb[$];

    seq_mag_comparator_if #(.WIDTH(WIDTH)) bus ();

    seq_mag_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: pops one expectation per done pulse; also watches flags stay frozen during RUN.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) begin
                check_output("done_single_not_busy", {30'd0, bus.busy, prev_done}, 32'd0);
                if (sb.size() == 0) begin
                    check_output("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_output("flags", {29'd0, bus.aeqb, bus.agtb, bus.altb}, {29'd0, e.flags});
                    check_output("latency", cycle - e.start_cycle, e.lat);
                    last_flags = e.flags;
                    done_count++;
                end
            end else if (bus.busy) begin
                check_output("flags_hold_in_run", {29'd0, bus.aeqb, bus.agtb, bus.altb}, {29'd0, last_flags});
            end
            prev_done = bus.done;
        end
    end

    function automatic int pick_lat(input int lat_early);
`ifdef CMP_EARLY_EXIT_EN
        return lat_early;
`else
        return (lat_early > 0) ? 4 : 4;
`endif
    endfunction

    task automatic push_exp(input logic [2:0] flags, input int lat_early);
        exp_t e;
        e.flags       = flags;
        e.lat         = pick_lat(lat_early);
        e.start_cycle = cycle;
        sb.push_back(e);
        issued++;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.busy && !bus.done) break;
        end
        check_output("drain_timeout", sb.size(), 0);
    endtask

    task automatic apply_stimulus(input vec_t v, input bit wait_done);
        @(negedge clk);
        bus.a         = v.a;
        bus.b         = v.b;
        bus.is_signed = v.s;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        push_exp(v.flags, v.lat_early);
        check_output("busy_after_accept", bus.busy, 1);
        @(negedge clk);
        bus.start = 1'b0;
        if (wait_done) wait_idle();
    endtask

    task automatic check_all_zero(input string name);
        check_output(name, {27'd0, bus.busy, bus.done, bus.aeqb, bus.agtb, bus.altb}, 32'd0);
    endtask

    vec_t vecs[9];
    vec_t v;

    initial begin
        cycle = 0; errors = 0; checks = 0; done_count = 0; issued = 0;
        prev_done = 1'b0; last_flags = 3'b000;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.is_signed = 1'b0;

        vecs[0] = '{8'h80, 8'h7F, 1'b1, F_LT, 1};
        vecs[1] = '{8'h80, 8'h7F, 1'b0, F_GT, 1};
        vecs[2] = '{8'hA5, 8'hA5, 1'b0, F_EQ, 4};
        vecs[3] = '{8'hC0, 8'h40, 1'b0, F_GT, 1};
        vecs[4] = '{8'hFF, 8'hFE, 1'b1, F_GT, 4};
        vecs[5] = '{8'hFE, 8'hFF, 1'b1, F_LT, 4};
        vecs[6] = '{8'h34, 8'h38, 1'b0, F_LT, 3};
        vecs[7] = '{8'h05, 8'h85, 1'b1, F_GT, 1};
        vecs[8] = '{8'hA5, 8'hA5, 1'b1, F_EQ, 4};

        #12;
        check_all_zero("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("idle_after_reset");

        foreach (vecs[i]) apply_stimulus(vecs[i], 1'b1);

        // Start held high through RUN with changing operands: only the first pair counts.
        @(negedge clk);
        bus.a = 8'h3C; bus.b = 8'h3C; bus.is_signed = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        push_exp(F_EQ, 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.a = bus.a + 8'h11;
            bus.b = bus.b - 8'h22;
            bus.is_signed = ~bus.is_signed;
        end
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        check_output("done_count_hold", done_count, issued);

        // Back-to-back: second start lands in the done cycle of the first.
        v = '{8'hA5, 8'hA5, 1'b0, F_EQ, 4};
        apply_stimulus(v, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (bus.done) break;
            @(negedge clk);
        end
        check_output("b2b_done_seen", bus.done, 1);
        bus.a = 8'h01; bus.b = 8'h02; bus.is_signed = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        push_exp(F_LT, 4);
        check_output("b2b_busy", bus.busy, 1);
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        check_output("done_count_b2b", done_count, issued);

        // Asynchronous reset two cycles into RUN discards the operation.
        @(negedge clk);
        bus.a = 8'h01; bus.b = 8'h02; bus.is_signed = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        check_output("busy_before_reset", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_midrun");
        last_flags = 3'b000;
        prev_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_all_zero("quiet_after_reset");

        apply_stimulus(vecs[6], 1'b1);
        check_output("done_count_final", done_count, issued);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
